sample_capture: RTL
===================

Name: sample_capture

Overview:
- Capture end of the waveform path: accepts a sample stream (e.g. the sine generator output or an ADC stream) and records a triggered window of 2^A_WIDTH samples into an internal RAM for readback.
- Complements the generator, which reads a ROM through an address counter: this block writes a RAM through an address counter.
- Trigger source is a rising crossing of a programmable level, or a forced trigger.
- Readback is a registered, random-access read port for a display, UART dumper or testbench.

Parameters:
- A_WIDTH, 8, capture RAM address width; capture depth = 2^A_WIDTH samples.
- D_WIDTH, 8, sample width (unsigned).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  sample strobe; din is valid when high.
- din  input  D_WIDTH  input sample, unsigned.
- level  input  D_WIDTH  trigger threshold, unsigned; sampled every cycle.
- arm  input  1  single-cycle pulse; starts waiting for a trigger.
- force_trig  input  1  immediate trigger while armed.
- rd_addr  input  A_WIDTH  readback address.
- rd_data  output  D_WIDTH  readback data, registered.
- busy  output  1  high in ARMED or CAPTURE.
- done  output  1  high in DONE.

Behaviour:
- Reset (rst low at a clk edge):
  - state = IDLE; write address = 0; prev_valid = 0; rd_data = 0; busy = 0; done = 0.
  - RAM contents are not cleared.
  - Reset mid-capture aborts the capture and returns to IDLE.
- States: IDLE, ARMED, CAPTURE, DONE. busy and done decode combinationally from the state register.
- IDLE:
  - arm=1 -> ARMED next cycle.
  - On that same arm edge: prev_valid cleared, write address cleared.
- ARMED:
  - On each en: prev <= din; prev_valid <= 1.
  - Level trigger = en && prev_valid && (prev < level) && (din >= level).
  - On level trigger: din is written to address 0 in the same cycle; write address -> 1; state -> CAPTURE.
  - On force_trig with en=1: same as a level trigger (the current sample is written to address 0).
  - On force_trig with en=0: state -> CAPTURE; write address stays 0; nothing is written.
  - Level trigger and force_trig in the same cycle: treated as one trigger.
- CAPTURE:
  - Each en writes din at the write address, then the address increments.
  - The write to address 2^A_WIDTH-1 moves state -> DONE on the same edge. The address wraps to 0 and no further writes occur.
  - Cycles with en=0 hold everything.
- DONE:
  - Holds until arm=1 -> ARMED. Same clears as from IDLE; done drops the next cycle.
- arm is ignored in ARMED and CAPTURE. force_trig is ignored outside ARMED.
- Read port:
  - rd_data <= RAM[rd_addr] every cycle, in every state; latency 1 cycle.
  - Same-address read and write in one cycle returns the old data (read-before-write).
- Arithmetic: all comparisons unsigned, D_WIDTH bits. Write address is A_WIDTH bits and wraps modulo 2^A_WIDTH.
- Exactly 2^A_WIDTH samples are written per capture when the trigger carries a sample. With force_trig and en=0, capture still ends after the write to address 2^A_WIDTH-1, i.e. 2^A_WIDTH samples.

Decomposition:
- Package sample_capture_pkg holds:
  - cap_state_t enum {IDLE, ARMED, CAPTURE, DONE}, 2-bit.
  - localparams for state encodings.
- Sub-module capture_ram holds the storage: simple dual-port RAM with A_WIDTH/D_WIDTH parameters, synchronous write (clk, we, waddr, wdata) and registered read (raddr, rdata). It mirrors the existing ROM's registered-read style.
- The top level holds the FSM, address counter and trigger compare.

Test Plan:
- Reset: hold rst=0 for 3 cycles with arm=1 -> busy=0, done=0, rd_data=0; after release, state is IDLE until the next arm.
- Level trigger: level=0x80, arm, feed en=1 ramp 0x00,0x10,...,0xF0 repeating -> first write is 0x80 at addr 0; read addr 0..3 returns 0x80,0x90,0xA0,0xB0; done rises right after the 256th sample.
- No trigger on first sample: arm, then first sample 0xFF with level=0x80 -> stays ARMED (prev_valid=0); then 0x00, 0x80 -> triggers on 0x80.
- force_trig with en=0, then 256 strobes of din=addr value -> RAM[i]=i for all i; done=1; busy=0.
- Gapped strobes: en high 1 cycle in 3 during CAPTURE -> state and address hold on en=0 cycles; content is contiguous with no holes.
- Reset mid-capture after 100 samples, then re-arm and capture -> new data overwrites from addr 0; rd_addr=0xFF read before re-arm returns the stale value with 1-cycle latency.

Source files
------------

// File: rtl/sample_capture_pkg.sv
// Shared types for the triggered sample-capture block: FSM state encoding.
package sample_capture_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ARMED   = 2'b01;
  localparam logic [1:0] ST_CAPTURE = 2'b10;
  localparam logic [1:0] ST_DONE    = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARMED   = ST_ARMED,
    CAPTURE = ST_CAPTURE,
    DONE    = ST_DONE
  } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture RAM: synchronous write, registered read.
// A read of the address being written returns the old word.
module capture_ram #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register: only this output word is cleared on reset, never the array.
  always_ff @(posedge clk) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_capture.sv
// Triggered capture of 2^A_WIDTH unsigned samples into RAM, with a
// registered random-access readback port.
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic [D_WIDTH-1:0] level,
  input  logic               arm,
  input  logic               force_trig,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               busy,
  output logic               done
);

  localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

  cap_state_t         state, state_n;
  logic [A_WIDTH-1:0] waddr, waddr_n;
  logic [D_WIDTH-1:0] prev;
  logic               prev_valid, prev_valid_n;
  logic               lvl_trig;
  logic               we;

  // Rising crossing: previous sample strictly below level, current at or above.
  assign lvl_trig = en && prev_valid && (prev < level) && (din >= level);

  always_comb begin
    state_n      = state;
    waddr_n      = waddr;
    prev_valid_n = prev_valid;
    we           = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          state_n      = ARMED;
          waddr_n      = '0;
          prev_valid_n = 1'b0;
        end
      end
      ARMED: begin
        if (en) prev_valid_n = 1'b1;
        // A strobed trigger sample lands at address 0; a forced trigger
        // without a strobe leaves the address at 0 for the first capture write.
        if (lvl_trig || force_trig) begin
          state_n = CAPTURE;
          if (en) begin
            we      = 1'b1;
            waddr_n = waddr + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (en) begin
          we      = 1'b1;
          waddr_n = waddr + 1'b1;
          if (waddr == LAST_ADDR) state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      waddr      <= '0;
      prev_valid <= 1'b0;
    end else begin
      state      <= state_n;
      waddr      <= waddr_n;
      prev_valid <= prev_valid_n;
    end
  end

  // Previous-sample register is data only; prev_valid qualifies it.
  always_ff @(posedge clk) begin
    if (state == ARMED && en) prev <= din;
  end

  assign busy = (state == ARMED) || (state == CAPTURE);
  assign done = (state == DONE);

  capture_ram #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
